// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive FIFO read words into one wide output word.
// A flush closes a partially filled word early; out_keep marks the valid lanes.
module fifo_word_packer #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [IN_W-1:0]       fifo_dout,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IN_W*RATIO-1:0] out_data,
   output logic [RATIO-1:0]      out_keep,
   output logic                  out_last
);
   localparam int CW = $clog2(RATIO + 1);

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       pend_q, pend_d;
   logic                       fpend_q, fpend_d;
   logic [RATIO-1:0][IN_W-1:0] lanes_q, lanes_d;
   logic [RATIO-1:0]           keep_q, keep_d;
   logic                       last_q, last_d;
   logic                       flush_eff, room;

   function automatic logic [RATIO-1:0] lane_mask(input logic [CW-1:0] c);
      logic [RATIO-1:0] m;
      for (int i = 0; i < RATIO; i++) m[i] = (i < int'(c));
      return m;
   endfunction

   // A flush is only meaningful while something is captured or on its way.
   assign flush_eff  = flush && (state_q == FILL) && !fpend_q && ((cnt_q != '0) || pend_q);
   assign room       = (int'(cnt_q) + int'(pend_q)) < RATIO;
   // Blocking on flush_eff keeps a new read from starting behind a flush.
   assign fifo_rd_en = !rst && (state_q == FILL) && !fifo_empty && room && !fpend_q && !flush_eff;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      fpend_d = fpend_q;
      lanes_d = lanes_q;
      keep_d  = keep_q;
      last_d  = last_q;
      case (state_q)
         FILL: begin
            pend_d = fifo_rd_en;
            if (pend_q) begin
               for (int i = 0; i < RATIO; i++)
                  if (i == int'(cnt_q)) lanes_d[i] = fifo_dout;
               cnt_d = cnt_q + CW'(1);
            end
            if (pend_q && (int'(cnt_q) + 1 == RATIO)) begin
               state_d = HOLD;
               keep_d  = '1;
               last_d  = fpend_q || flush_eff;
               fpend_d = 1'b0;
            end else if (flush_eff && pend_q) begin
               fpend_d = 1'b1;
            end else if ((flush_eff || fpend_q) && !pend_q) begin
               state_d = HOLD;
               keep_d  = lane_mask(cnt_q);
               last_d  = 1'b1;
               fpend_d = 1'b0;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = FILL;
               cnt_d   = '0;
               lanes_d = '0;
               keep_d  = '0;
               last_d  = 1'b0;
               fpend_d = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         fpend_q <= 1'b0;
         lanes_q <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         fpend_q <= fpend_d;
         lanes_q <= lanes_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_data  = lanes_q;
   assign out_keep  = keep_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-modelled FIFO, scoreboard of packed words,
// table of word/flush cases plus hand sequences for the multi-cycle corners.
module tb_fifo_word_packer;
   localparam int IN_W  = 8;
   localparam int RATIO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd_en;
   logic [7:0]  fifo_dout = 8'h00;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;

   fifo_word_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   typedef struct {
      int          n;
      logic [7:0]  b0, b1, b2, b3;
      logic        fl;
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } vec_t;

   logic [7:0] fq[$];
   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   int         rd_total = 0;

   // Upstream FIFO: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (fifo_rd_en && fq.size() != 0) begin
         fifo_dout <= fq.pop_front();
         rd_total  <= rd_total + 1;
      end
      fifo_empty <= (fq.size() == 0);
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         checks++;
         if (fifo_rd_en && fifo_empty) begin
            failures++;
            $display("FAIL rd_while_empty rd_en=%b empty=%b", fifo_rd_en, fifo_empty);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word got data=%h keep=%h last=%b", out_data, out_keep, out_last);
            end else begin
               e = sb.pop_front();
               if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
                  failures++;
                  $display("FAIL word got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                           out_data, out_keep, out_last, e.d, e.k, e.l);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t e;
      e.d = d; e.k = k; e.l = l;
      sb.push_back(e);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
      tick();
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t vecs[6];

   initial begin
      int lat, t, n, base;
      logic [31:0] held;

      vecs[0] = '{4, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h44332211, 4'hF, 1'b0};
      vecs[1] = '{4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 32'hEFBEADDE, 4'hF, 1'b0};
      vecs[2] = '{2, 8'hAA, 8'hBB, 8'h00, 8'h00, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
      vecs[3] = '{1, 8'h5C, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0000005C, 4'h1, 1'b1};
      vecs[4] = '{3, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 32'h00030201, 4'h7, 1'b1};
      vecs[5] = '{4, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 32'hFF00FF00, 4'hF, 1'b0};

      // Reset with a non-empty FIFO: no reads, outputs cleared.
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      fq.push_back(8'h10); fq.push_back(8'h11); fq.push_back(8'h12); fq.push_back(8'h13);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_empty", {63'd0, fifo_empty}, 64'd0);
         chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
         chk("rst_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_data", {32'd0, out_data}, 64'd0);
         chk("rst_keep", {60'd0, out_keep}, 64'd0);
      end
      tick();
      rst = 1'b0;
      expect_word(32'h13121110, 4'hF, 1'b0);
      drain();

      // Flush with nothing captured is ignored.
      repeat (3) tick();
      flush = 1'b1; tick(); flush = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("idle_flush_valid", {63'd0, out_valid}, 64'd0);
      end
      tick();

      foreach (vecs[i]) begin
         if (vecs[i].n > 0) fq.push_back(vecs[i].b0);
         if (vecs[i].n > 1) fq.push_back(vecs[i].b1);
         if (vecs[i].n > 2) fq.push_back(vecs[i].b2);
         if (vecs[i].n > 3) fq.push_back(vecs[i].b3);
         expect_word(vecs[i].d, vecs[i].k, vecs[i].l);
         if (!vecs[i].fl) begin
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!fifo_rd_en && t < 20);
            wait_valid(lat);
            chk("full_latency_ok", {63'd0, (out_valid && lat <= 6)}, 64'd1);
         end else begin
            repeat (8) tick();
            chk("pre_flush_valid", {63'd0, out_valid}, 64'd0);
            flush = 1'b1; tick(); flush = 1'b0;
         end
         drain();
      end

      // Backpressure: word held stable, no reads while waiting.
      out_ready = 1'b0;
      for (int b = 0; b < 8; b++) fq.push_back(8'(8'h21 + b));
      expect_word(32'h24232221, 4'hF, 1'b0);
      expect_word(32'h28272625, 4'hF, 1'b0);
      wait_valid(lat);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         held = out_data;
         chk("bp_data", {32'd0, held}, 64'h24232221);
         chk("bp_rd_en", {63'd0, fifo_rd_en}, 64'd0);
         chk("bp_nonempty", {63'd0, fifo_empty}, 64'd0);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_accept_one_edge", {63'd0, out_valid}, 64'd0);
      drain();

      // Flush during the third in-flight read: no fourth read.
      base = rd_total;
      fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
      expect_word(32'h00030201, 4'h7, 1'b1);
      n = 0; t = 0;
      while (n < 3 && t < 30) begin
         @(negedge clk);
         if (fifo_rd_en) n++;
         t++;
      end
      chk("inflight_3_reads_seen", 64'(n), 64'd3);
      tick();
      flush = 1'b1; tick(); flush = 1'b0;
      #3;
      wait_valid(lat);
      chk("inflight_valid", {63'd0, out_valid}, 64'd1);
      chk("inflight_reads", 64'(rd_total - base), 64'd3);
      drain();
      fq.push_back(8'h05); fq.push_back(8'h06); fq.push_back(8'h07);
      expect_word(32'h07060504, 4'hF, 1'b0);
      drain();

      // Reset in the middle of a word discards the partial data.
      fq.push_back(8'h91); fq.push_back(8'h92); fq.push_back(8'h93);
      repeat (8) tick();
      chk("mid_partial_valid", {63'd0, out_valid}, 64'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_data", {32'd0, out_data}, 64'd0);
      chk("mid_rst_keep", {60'd0, out_keep}, 64'd0);
      tick();
      fq.push_back(8'h5A); fq.push_back(8'h6B); fq.push_back(8'h7C); fq.push_back(8'h8D);
      expect_word(32'h8D7C6B5A, 4'hF, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
